// File: rtl/keypad_scanner.sv
// Scanning controller for a 3-column x 4-row matrix keypad.
// Drives one column low at a time, samples the synchronised active-low rows
// at the end of each column window, debounces complete 12-key snapshots and
// reports single key presses as one-cycle events.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [2:0] COL_N,
  input  logic [3:0] ROW_N,
  output logic       KEY_VALID,
  output logic [3:0] KEY_CODE,
  output logic       KEY_HELD,
  output logic       ERROR
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [11:0]      frame_q, frame_d;
  logic [11:0]      last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      deb_q, deb_d;
  logic             deb_chg_q, deb_chg_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic             held_q, held_d;
  logic             err_q, err_d;

  logic        sample;
  logic        frame_end;
  logic        reach;
  logic [11:0] snap;
  logic [3:0]  pop;
  logic [3:0]  idx;

  // Column sequencer, row sampling and snapshot debounce.
  always_comb begin
    sync1_d   = ROW_N;
    sync2_d   = sync1_q;
    div_d     = div_q + DIV_W'(1);
    col_d     = col_q;
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (col_q == 2'd2);
    snap      = frame_q;
    // Snapshot bit layout is col*4+row; 1 means pressed.
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (col_q == 2'(c)) snap[c*4+r] = ~sync2_q[r];
      end
    end
    frame_d = sample ? snap : frame_q;
    if (sample) begin
      div_d = '0;
      col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    end

    last_d    = last_q;
    cnt_d     = cnt_q;
    deb_d     = deb_q;
    deb_chg_d = 1'b0;
    reach     = 1'b0;
    if (frame_end) begin
      if (snap != last_q) begin
        last_d = snap;
        cnt_d  = CNT_W'(1);
        // A fresh snapshot counts as its first stable frame.
        reach  = (DEBOUNCE == 1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
        reach = ((cnt_q + CNT_W'(1)) == CNT_MAX);
      end
      if (reach && (snap != deb_q)) begin
        deb_d     = snap;
        deb_chg_d = 1'b1;
      end
    end
  end

  // Classify the debounced state one cycle after it changes.
  always_comb begin
    pop = '0;
    idx = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (deb_q[c*4+r]) begin
          pop = pop + 4'd1;
          idx = 4'(r*3 + c);
        end
      end
    end
    valid_d = 1'b0;
    code_d  = code_q;
    held_d  = held_q;
    err_d   = err_q;
    if (deb_chg_q) begin
      if (pop == 4'd1) begin
        valid_d = 1'b1;
        code_d  = idx;
        held_d  = 1'b1;
        err_d   = 1'b0;
      end else if (pop == 4'd0) begin
        held_d = 1'b0;
        err_d  = 1'b0;
      end else begin
        held_d = 1'b0;
        err_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      div_q     <= '0;
      col_q     <= '0;
      frame_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      deb_q     <= '0;
      deb_chg_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      held_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_chg_q <= deb_chg_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      held_q    <= held_d;
      err_q     <= err_d;
    end
  end

  assign COL_N     = ~(3'b001 << col_q);
  assign KEY_VALID = valid_q;
  assign KEY_CODE  = code_q;
  assign KEY_HELD  = held_q;
  assign ERROR     = err_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a combinational keypad emulator.
// Keys are given as a 12-bit mask indexed by code = row*3+col.
module tb_keypad_scanner;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] COL_N;
  logic [3:0] ROW_N;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_HELD;
  logic       ERROR;

  logic [11:0] pressed = '0;
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .COL_N(COL_N), .ROW_N(ROW_N),
    .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE), .KEY_HELD(KEY_HELD), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  // Keypad emulator: a pressed key shorts its row to its driven column.
  always_comb begin
    ROW_N = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !COL_N[c]) ROW_N[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // KEY_VALID must never be high on two consecutive cycles.
  always @(negedge CLK) begin
    if (KEY_VALID) chk("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
    prev_valid = KEY_VALID;
  end

  task automatic run(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge CLK);
      if (KEY_VALID) pulses++;
    end
  endtask

  typedef struct {
    logic [11:0] keys;
    int          pulses;
    logic [3:0]  code;
    logic        held;
    logic        err;
  } vec_t;

  vec_t vecs[8];
  int   p;

  initial begin
    vecs[0] = '{12'h000,              0, 4'd0,  1'b0, 1'b0};
    vecs[1] = '{12'h020,              1, 4'd5,  1'b1, 1'b0}; // row1 col2
    vecs[2] = '{12'h000,              0, 4'd5,  1'b0, 1'b0};
    vecs[3] = '{12'h081,              0, 4'd5,  1'b0, 1'b1}; // keys 0 and 7
    vecs[4] = '{12'h080,              1, 4'd7,  1'b1, 1'b0}; // drop key 0
    vecs[5] = '{12'h800,              1, 4'd11, 1'b1, 1'b0}; // single to single
    vecs[6] = '{12'h421,              0, 4'd11, 1'b0, 1'b1}; // three keys
    vecs[7] = '{12'h000,              0, 4'd11, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_col_n", {29'd0, COL_N}, 32'h6);
    chk("rst_valid", {31'd0, KEY_VALID}, 32'd0);
    chk("rst_code",  {28'd0, KEY_CODE}, 32'd0);
    chk("rst_held",  {31'd0, KEY_HELD}, 32'd0);
    chk("rst_error", {31'd0, ERROR}, 32'd0);

    // Column sequence with idle rows
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [2:0] exp_col;
      exp_col = ~(3'b001 << (i / 4));
      chk("col_seq", {29'd0, COL_N}, {29'd0, exp_col});
      @(negedge CLK);
    end

    // Table of steady key patterns
    for (int v = 0; v < 8; v++) begin
      pressed = vecs[v].keys;
      run(72, p);
      chk($sformatf("vec%0d_pulses", v), p, vecs[v].pulses);
      chk($sformatf("vec%0d_code", v), {28'd0, KEY_CODE}, {28'd0, vecs[v].code});
      chk($sformatf("vec%0d_held", v), {31'd0, KEY_HELD}, {31'd0, vecs[v].held});
      chk($sformatf("vec%0d_error", v), {31'd0, ERROR}, {31'd0, vecs[v].err});
    end

    // Release waits for the full debounce before KEY_HELD drops
    pressed = 12'h010; // key 4
    run(72, p);
    chk("rel_press_pulse", p, 1);
    pressed = 12'h000;
    run(20, p);
    chk("rel_held_early", {31'd0, KEY_HELD}, 32'd1);
    chk("rel_early_pulse", p, 0);
    run(52, p);
    chk("rel_held_late", {31'd0, KEY_HELD}, 32'd0);
    chk("rel_late_pulse", p, 0);
    chk("rel_code", {28'd0, KEY_CODE}, 32'd4);

    // Bouncing press of key 9 (row3 col0) then stable
    begin
      int total;
      total = 0;
      for (int b = 0; b < 5; b++) begin
        pressed = (b % 2 == 0) ? 12'h200 : 12'h000;
        run(5, p);
        total += p;
      end
      pressed = 12'h200;
      run(72, p);
      total += p;
      chk("bounce_pulses", total, 1);
      chk("bounce_code", {28'd0, KEY_CODE}, 32'd9);
      chk("bounce_held", {31'd0, KEY_HELD}, 32'd1);
    end

    // Short glitch on key 3 from idle is rejected
    pressed = 12'h000;
    run(72, p);
    pressed = 12'h008;
    run(12, p);
    begin
      int total;
      total = p;
      pressed = 12'h000;
      run(72, p);
      total += p;
      chk("glitch_pulses", total, 0);
    end
    chk("glitch_code", {28'd0, KEY_CODE}, 32'd9);
    chk("glitch_held", {31'd0, KEY_HELD}, 32'd0);

    // Reset in the middle of debouncing key 7
    pressed = 12'h800;
    run(72, p);
    chk("pre_rst_code", {28'd0, KEY_CODE}, 32'd11);
    pressed = 12'h080;
    run(20, p);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_col_n", {29'd0, COL_N}, 32'h6);
    chk("mid_rst_valid", {31'd0, KEY_VALID}, 32'd0);
    chk("mid_rst_code",  {28'd0, KEY_CODE}, 32'd0);
    chk("mid_rst_held",  {31'd0, KEY_HELD}, 32'd0);
    chk("mid_rst_error", {31'd0, ERROR}, 32'd0);
    RST_N = 1'b1;
    run(72, p);
    chk("post_rst_pulses", p, 1);
    chk("post_rst_code", {28'd0, KEY_CODE}, 32'd7);
    chk("post_rst_held", {31'd0, KEY_HELD}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
